// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory that answers one request at a
// time after a fixed latency, with byte-lane masked writes.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_q, wr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          valid_q;
    logic [31:0]   rdata_q;
    logic          commit;
    logic [31:0]   stored;
    logic [31:0]   merged;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ip_data_addr[31:AW+2], ip_data_addr[1:0]};

    // The *_d request fields always describe the request being committed, so
    // a LATENCY of 1 commits straight from the inputs in the capture cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ip_data_rd || ip_data_wr) begin
                    idx_d   = ip_data_addr[AW+1:2];
                    wr_d    = ip_data_wr;
                    mask_d  = ip_data_mask;
                    wdata_d = ip_data_from_proc;
                    cnt_d   = '0;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stored = mem_q[idx_d];
        merged = stored;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_d && mask_d[i]) begin
                merged[8*i +: 8] = wdata_d[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            mask_q  <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            valid_q <= commit;
            if (commit) begin
                rdata_q <= merged;
            end
        end
    end

    // Contents survive reset; the reset gate stops a commit while reset is low.
    always_ff @(posedge clk) begin
        if (reset && commit && wr_d) begin
            mem_q[idx_d] <= merged;
        end
    end

    assign op_data_valid   = valid_q;
    assign op_data_to_proc = rdata_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, memory size in 32-bit words; SHALL be a power of two.
REQ-002 Parameter LATENCY, default 2, request-to-response cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 ip_data_addr  input  32  byte address from the processor.
REQ-006 ip_data_wr  input  1  write request.
REQ-007 ip_data_mask  input  4  byte-lane write enables; bit i covers bits 8i+7..8i.
REQ-008 ip_data_from_proc  input  32  write data.
REQ-009 ip_data_rd  input  1  read request.
REQ-010 op_data_valid  output  1  one-cycle response strobe.
REQ-011 op_data_to_proc  output  32  read / post-write word.

Function
REQ-012 FSM SHALL have three states: IDLE, WAIT, RESP; only one request outstanding.
REQ-013 In IDLE, ip_data_rd or ip_data_wr high at a rising edge SHALL capture addr, wr, rd, mask and data, then enter WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-014 Requests present in WAIT or RESP SHALL be ignored; none are queued.
REQ-015 WAIT SHALL count with a 4-bit counter and exit to RESP after LATENCY-1 cycles in WAIT.
REQ-016 Request sampled in IDLE during cycle c SHALL produce op_data_valid high in cycle c+LATENCY only, for exactly one cycle.
REQ-017 RESP SHALL return to IDLE unconditionally on the next edge; the requester deasserts in the cycle after valid, else the held request is taken as new.
REQ-018 Word index SHALL be addr[31:2] modulo DEPTH_WORDS; addr[1:0] ignored; out-of-range addresses wrap, no error.
REQ-019 Write SHALL commit only on the edge entering RESP; it updates only lanes whose mask bit is 1.
REQ-020 Mask 4'b0000 with wr SHALL leave memory unchanged and still pulse valid.
REQ-021 Read-only: op_data_to_proc SHALL be the stored word at the commit edge.
REQ-022 rd and wr both high: write SHALL commit and op_data_to_proc SHALL be the merged post-write word.
REQ-023 Write-only: op_data_to_proc SHALL be the merged post-write word.
REQ-024 op_data_to_proc SHALL hold its last value outside the valid cycle.

Reset
REQ-025 reset low SHALL force IDLE, counter 0, op_data_valid 0 and op_data_to_proc 0 immediately.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 Reset during WAIT SHALL drop the in-flight request: no write commit, no valid pulse.
REQ-028 First request SHALL be accepted at the first rising edge with reset high.

Verification (LATENCY=2, DEPTH_WORDS=1024)
REQ-029 Write 0xDEADBEEF, mask 1111, addr 0x10, sampled cycle 5 -> valid high cycle 7 only, data 0xDEADBEEF; read 0x10 -> 0xDEADBEEF.
REQ-030 Write 0x000000AA mask 0001 then 0x0000BB00 mask 0010 to addr 0x10 holding 0xDEADBEEF -> read returns 0xDEADBBAA.
REQ-031 Read addr 0x1013 after writing 0x12345678 to addr 0x10 -> returns 0x12345678 (wrap and low bits ignored).
REQ-032 Second request raised during WAIT -> ignored, one valid pulse; request held through RESP -> second response LATENCY cycles after the IDLE cycle.
REQ-033 Write 0xFFFFFFFF to 0x20 (holding 0x0), reset low during WAIT -> valid stays 0; read 0x20 -> 0x00000000.
REQ-034 rd+wr, data 0x11223344 mask 1100, addr 0x30 holding 0xAAAAAAAA -> valid with 0x1122AAAA; mask 0000 write -> valid, memory unchanged.
